rl_scfifo_wrarb: RTL and testbench

//  Round-robin write arbiter that shares one single-clock FIFO write port among REQUESTERS sources.

---
 rtl/rl_fifo_arb_pkg.sv | 31 +++
 rtl/rl_scfifo_wrarb_rr_picker.sv | 34 +++
 rtl/rl_scfifo_wrarb.sv | 95 +++++++++
 tb/tb_rl_scfifo_wrarb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rl_fifo_arb_pkg.sv
// Shared types and a reference round-robin search for the rl_scfifo write arbiter.
package rl_fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_t;

  localparam int MAX_REQ = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] searching upward from ptr+1, wrapping modulo n.
  function automatic rr_pick_t rr_next(input logic [MAX_REQ-1:0] req,
                                       input logic [3:0] ptr, input int n);
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= n) begin
        k = (int'(ptr) + i) % n;
        if (req[k]) begin
          r.found = 1'b1;
          r.idx   = 4'(k);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rl_scfifo_wrarb_rr_picker.sv
// rl_rr_picker: combinational round-robin pick. Rotates the request vector so the
// slot after ptr_i sits at bit 0, takes the lowest set bit, then maps it back.
module rl_rr_picker #(
  parameter int REQUESTERS = 4,
  parameter int ID_SIZE    = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] req_i,
  input  logic [ID_SIZE-1:0]    ptr_i,
  output logic                  found_o,
  output logic [ID_SIZE-1:0]    idx_o
);

  logic [2*REQUESTERS-1:0] dbl;
  logic [REQUESTERS-1:0]   rot;
  int                      start;
  int                      off;
  int                      sum;

  // rotate, priority-encode lowest bit, unrotate
  always_comb begin
    start = (int'(ptr_i) == REQUESTERS - 1) ? 0 : int'(ptr_i) + 1;
    dbl   = {req_i, req_i};
    rot   = REQUESTERS'(dbl >> start);
    found_o = |rot;
    off = 0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    sum = start + off;
    if (sum >= REQUESTERS) sum = sum - REQUESTERS;
    idx_o = ID_SIZE'(sum);
  end

endmodule

// File: rtl/rl_scfifo_wrarb.sv
// rl_scfifo_wrarb: round-robin arbiter sharing one rl_scfifo write port among
// REQUESTERS sources, with locked (packet) ownership.
// Optional feature: define RL_FIFO_ARB_BURST_LIMIT_EN to cap each locked
// ownership at MAX_BURST beats.
module rl_scfifo_wrarb
  import rl_fifo_arb_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int DATA_SIZE  = 32,
  parameter int MAX_BURST  = 16,
  parameter int ID_SIZE    = $clog2(REQUESTERS)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clr_i,
  input  logic [REQUESTERS-1:0]           req_i,
  input  logic [REQUESTERS-1:0]           lock_i,
  input  logic [REQUESTERS*DATA_SIZE-1:0] d_i,
  output logic [REQUESTERS-1:0]           gnt_o,
  output logic [DATA_SIZE-1:0]            fifo_d_o,
  output logic                            fifo_wrena_o,
  input  logic                            fifo_full_i,
  output logic                            busy_o,
  output logic [ID_SIZE-1:0]              owner_o
);

  arb_state_t                            state_q;
  logic [ID_SIZE-1:0]                    rr_q, owner_q, win_idx, sel;
  logic                                  win_found, stall, beat, keep;
  logic [REQUESTERS-1:0][DATA_SIZE-1:0]  d_arr;

`ifdef RL_FIFO_ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
`endif

  assign d_arr   = d_i;
  assign busy_o  = (state_q == OWN);
  assign owner_o = owner_q;

  rl_rr_picker #(
    .REQUESTERS(REQUESTERS),
    .ID_SIZE   (ID_SIZE)
  ) u_pick (
    .req_i  (req_i),
    .ptr_i  (rr_q),
    .found_o(win_found),
    .idx_o  (win_idx)
  );

  // beat decision, grant, data mux and whether ownership continues past this beat
  always_comb begin
    // an illegal MAX_BURST (<1) parks the arbiter rather than misbehaving
    stall = rst_i | clr_i | fifo_full_i | (MAX_BURST < 1);
    sel   = (state_q == OWN) ? owner_q : win_idx;
    beat  = ~stall & ((state_q == OWN) ? req_i[owner_q] : win_found);
    gnt_o = '0;
    if (beat) gnt_o[sel] = 1'b1;
    fifo_wrena_o = beat;
    fifo_d_o     = d_arr[beat ? sel : rr_q];
    keep = lock_i[sel];
`ifdef RL_FIFO_ARB_BURST_LIMIT_EN
    cnt_nxt = (state_q == OWN) ? cnt_q + 1'b1 : CNT_W'(1);
    if (int'(cnt_nxt) >= MAX_BURST) keep = 1'b0;
`endif
  end

  // state, rr pointer, owner and burst count; rr only moves on arbitrated beats
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= ID_SIZE'(REQUESTERS - 1);
      owner_q <= '0;
`ifdef RL_FIFO_ARB_BURST_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else if (clr_i) begin
      state_q <= IDLE;
      rr_q    <= ID_SIZE'(REQUESTERS - 1);
`ifdef RL_FIFO_ARB_BURST_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else if (beat) begin
      if (state_q == IDLE) begin
        rr_q <= win_idx;
        if (keep) owner_q <= win_idx;
      end
      state_q <= keep ? OWN : IDLE;
`ifdef RL_FIFO_ARB_BURST_LIMIT_EN
      cnt_q   <= keep ? cnt_nxt : '0;
`endif
    end
  end

endmodule

// File: tb/tb_rl_scfifo_wrarb.sv
// Self-checking bench for rl_scfifo_wrarb (4 requesters, 32-bit data, MAX_BURST=4).
// Honours RL_FIFO_ARB_BURST_LIMIT_EN when it is defined for the build.
module tb_rl_scfifo_wrarb;

  localparam int R  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_i, clr_i, fifo_full_i;
  logic [R-1:0]  req_i, lock_i;
  logic [R*DW-1:0] d_i;
  logic [R-1:0]  gnt_o;
  logic [DW-1:0] fifo_d_o;
  logic          fifo_wrena_o, busy_o;
  logic [1:0]    owner_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model state: owner (-1 when free), last arbitration winner, beats in this ownership
  int m_owner = -1;
  int m_last  = R - 1;
  int m_cnt   = 0;
  int e;

  always #5 clk = ~clk;

  rl_scfifo_wrarb #(.REQUESTERS(R), .DATA_SIZE(DW), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .req_i(req_i), .lock_i(lock_i),
    .d_i(d_i), .gnt_o(gnt_o), .fifo_d_o(fifo_d_o), .fifo_wrena_o(fifo_wrena_o),
    .fifo_full_i(fifo_full_i), .busy_o(busy_o), .owner_o(owner_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] dval(input int n);
    return 32'hA000_0000 + 32'(n << 20) + 32'(cyc);
  endfunction

  function automatic int pick(input logic [R-1:0] r, input int last);
    for (int k = 1; k <= R; k++) if (r[(last + k) % R]) return (last + k) % R;
    return -1;
  endfunction

  // one stimulus cycle: apply inputs after the edge, return just past the falling edge
  task automatic drv(input logic [R-1:0] r, input logic [R-1:0] l,
                     input logic f, input logic c, input logic rs);
    @(posedge clk); #1;
    cyc++;
    for (int n = 0; n < R; n++) d_i[n*DW +: DW] = dval(n);
    req_i = r; lock_i = l; fifo_full_i = f; clr_i = c; rst_i = rs;
    @(negedge clk); #1;
  endtask

  // every cycle: compare against the model, then advance the model
  always @(negedge clk) begin
    if (rst_i || clr_i || fifo_full_i) e = -1;
    else if (m_owner >= 0) e = req_i[m_owner] ? m_owner : -1;
    else e = pick(req_i, m_last);
    chk("m_gnt", 32'(gnt_o), (e >= 0) ? (32'd1 << e) : 32'd0);
    chk("m_wrena", 32'(fifo_wrena_o), (e >= 0) ? 32'd1 : 32'd0);
    if (e >= 0) chk("m_data", fifo_d_o, d_i[e*DW +: DW]);
    chk("m_busy", 32'(busy_o), (m_owner >= 0) ? 32'd1 : 32'd0);
    if (m_owner >= 0) chk("m_owner", 32'(owner_o), 32'(m_owner));
    if (rst_i || clr_i) begin
      m_owner = -1; m_last = R - 1; m_cnt = 0;
    end else if (e >= 0) begin
      if (m_owner < 0) begin
        m_last = e;
        m_cnt  = 1;
        if (lock_i[e]) m_owner = e;
      end else begin
        m_cnt++;
        if (!lock_i[e]) m_owner = -1;
      end
`ifdef RL_FIFO_ARB_BURST_LIMIT_EN
      if (m_cnt >= MB) m_owner = -1;
`endif
    end
  end

  int t1_src [5] = '{0, 1, 2, 3, 0};
`ifdef RL_FIFO_ARB_BURST_LIMIT_EN
  logic [3:0] t5_exp [12] = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h1, 4'h8, 4'h8, 4'h8, 4'h8, 4'h1, 4'h8, 4'h8};
`else
  logic [3:0] t5_exp [12] = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};
`endif

  initial begin
    rst_i = 1'b1; clr_i = 1'b0; fifo_full_i = 1'b0; req_i = '0; lock_i = '0; d_i = '0;

    // reset values and reset overriding requests
    drv(4'h0, 4'h0, 0, 0, 1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_owner", 32'(owner_o), 32'd0);
    drv(4'hF, 4'hF, 0, 0, 1);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_wrena", 32'(fifo_wrena_o), 32'd0);

    // 1: all requesting, no locks -> 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      drv(4'hF, 4'h0, 0, 0, 0);
      chk("t1_gnt", 32'(gnt_o), 32'd1 << t1_src[i]);
      chk("t1_data", fifo_d_o, dval(t1_src[i]));
    end
    drv(4'h0, 4'h0, 0, 0, 0);

    // 2: src1 locked packet with a bubble; src0/src2 wait, then src2 next
    drv(4'b0111, 4'b0010, 0, 0, 0);
    chk("t2_gnt_a", 32'(gnt_o), 32'h2);
    drv(4'b0101, 4'b0010, 0, 0, 0);
    chk("t2_bubble", 32'(gnt_o), 32'h0);
    chk("t2_busy", 32'(busy_o), 32'd1);
    chk("t2_owner", 32'(owner_o), 32'd1);
    drv(4'b0111, 4'b0010, 0, 0, 0);
    chk("t2_gnt_b", 32'(gnt_o), 32'h2);
    drv(4'b0111, 4'b0000, 0, 0, 0);
    chk("t2_gnt_c", 32'(gnt_o), 32'h2);
    drv(4'b0101, 4'b0000, 0, 0, 0);
    chk("t2_next", 32'(gnt_o), 32'h4);
    chk("t2_free", 32'(busy_o), 32'd0);
    drv(4'h0, 4'h0, 0, 0, 0);

    // 3: FIFO full for 5 cycles, then src0 wins
    for (int i = 0; i < 5; i++) begin
      drv(4'b0101, 4'h0, 1, 0, 0);
      chk("t3_gnt_full", 32'(gnt_o), 32'h0);
      chk("t3_wrena_full", 32'(fifo_wrena_o), 32'd0);
    end
    drv(4'b0101, 4'h0, 0, 0, 0);
    chk("t3_release", 32'(gnt_o), 32'h1);

    // 4: clear during src2 ownership
    drv(4'b0100, 4'b0100, 0, 0, 0);
    chk("t4_own", 32'(gnt_o), 32'h4);
    drv(4'b1100, 4'b0100, 0, 1, 0);
    chk("t4_clr_gnt", 32'(gnt_o), 32'h0);
    drv(4'b1100, 4'b0000, 0, 0, 0);
    chk("t4_busy", 32'(busy_o), 32'd0);
    chk("t4_gnt", 32'(gnt_o), 32'h4);

    // 6: reset in the middle of a src3 packet
    drv(4'b1000, 4'b1000, 0, 0, 0);
    chk("t6_own", 32'(gnt_o), 32'h8);
    drv(4'hF, 4'hF, 0, 0, 1);
    chk("t6_rst_gnt", 32'(gnt_o), 32'h0);
    chk("t6_rst_wrena", 32'(fifo_wrena_o), 32'd0);
    drv(4'hF, 4'hF, 0, 0, 1);
    chk("t6_rst_gnt2", 32'(gnt_o), 32'h0);
    drv(4'b0001, 4'h0, 0, 0, 0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_owner", 32'(owner_o), 32'd0);
    chk("t6_gnt", 32'(gnt_o), 32'h1);

    // 5: src3 holds lock while src0 requests (burst cap only when enabled)
    for (int i = 0; i < 12; i++) begin
      drv(4'b1001, 4'b1000, 0, 0, 0);
      chk("t5_gnt", 32'(gnt_o), 32'(t5_exp[i]));
    end
    drv(4'b1000, 4'b0000, 0, 0, 0);
    chk("t5_last", 32'(gnt_o), 32'h8);
    drv(4'h0, 4'h0, 0, 0, 0);
    chk("t5_free", 32'(busy_o), 32'd0);

    // mixed traffic, model-checked only
    for (int i = 0; i < 60; i++)
      drv(4'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));

    drv(4'h0, 4'h0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
